// File: rtl/tick_timer_if.sv
// tick_timer_if -- bus between the tick_timer and its environment (divider + Simplez bus).
//
// Purpose: bundles the divider handshake (tick / timer_ena) and the CPU register
// strobes (wr / wdata / rd / rdata / busy / done) into one port.
//
// Protocol: wr and rd are single-cycle strobes sampled on the rising clock edge.
// There is no back-pressure: the timer accepts every strobe in the cycle it is high
// (an implicit ready that is always 1), so a strobe held for two cycles counts as two.
// tick is a 1-cycle pulse that is only acted on while timer_ena is 1.
//
// Signals:
//   tick       master->slave  1      divider clk_out pulse
//   timer_ena  slave->master  1      divider enable (0 holds divider at phase 0)
//   wr         master->slave  1      load wdata and start
//   wdata      master->slave  CNT_W  interval length in ticks
//   rd         master->slave  1      read/acknowledge strobe
//   rdata      slave->master  CNT_W  remaining tick count (registered)
//   busy       slave->master  1      counting
//   done       slave->master  1      sticky expiry flag
//   state      slave->master  2      FSM state for debug/checkers
interface tick_timer_if #(
    parameter int CNT_W = 12
);
    logic             tick;
    logic             timer_ena;
    logic             wr;
    logic [CNT_W-1:0] wdata;
    logic             rd;
    logic [CNT_W-1:0] rdata;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output tick, wr, wdata, rd,
        input  timer_ena, rdata, busy, done, state
    );

    modport slave (
        input  tick, wr, wdata, rd,
        output timer_ena, rdata, busy, done, state
    );
endinterface

// File: rtl/tick_timer.sv
// tick_timer -- CPU-programmable interval timer downstream of a 1-cycle tick divider.
//
// Purpose: counts N divider ticks after a write, then raises a sticky done flag that
// the CPU polls and acknowledges with rd. A write drops timer_ena for one cycle so the
// divider restarts at phase 0 and every interval is exactly N*M clk cycles.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   bus   tick_timer_if.slave (tick, timer_ena, wr, wdata, rd, rdata, busy, done, state)
//
// Configuration:
//   TICK_TIMER_AUTORELOAD_EN  when defined, expiry reloads the count and stays in RUN
//                             (periodic mode); otherwise the timer is single-shot.
//
// All outputs are flops; nothing combinational reaches the outputs from the inputs.
module tick_timer #(
    parameter int CNT_W = 12
) (
    input  logic         clk,
    input  logic         rst,
    tick_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_n;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] reload_n;
    logic [CNT_W-1:0] rdata_q;
    logic             done_q;
    logic             done_n;
    logic             ena_q;
    logic             busy_q;

    // Ticks only count while the divider is enabled, i.e. in RUN.
    logic tick_seen;
    assign tick_seen = (state == RUN) && bus.tick;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        reload_n    = reload;
        done_n      = done_q;

        if (bus.wr) begin
            // A write overrides everything else in the cycle, including rd and tick.
            if (bus.wdata != '0) begin
                remaining_n = bus.wdata;
                reload_n    = bus.wdata;
                done_n      = 1'b0;
                state_n     = RESTART;
            end else begin
                remaining_n = '0;
                done_n      = 1'b1;
                state_n     = DONE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                RESTART: begin
                    // One cycle with timer_ena low resets the divider phase.
                    state_n = RUN;
                end
                RUN: begin
`ifdef TICK_TIMER_AUTORELOAD_EN
                    if (bus.rd) begin
                        done_n = 1'b0;
                    end
                    if (tick_seen) begin
                        if (remaining > CNT_W'(1)) begin
                            remaining_n = remaining - CNT_W'(1);
                        end else begin
                            // Expiry reloads without a RESTART cycle, keeping the period phase-exact.
                            remaining_n = reload;
                            done_n      = 1'b1;
                        end
                    end
`else
                    if (tick_seen) begin
                        if (remaining > CNT_W'(1)) begin
                            remaining_n = remaining - CNT_W'(1);
                        end else begin
                            remaining_n = '0;
                            done_n      = 1'b1;
                            state_n     = DONE;
                        end
                    end
`endif
                end
                DONE: begin
                    if (bus.rd) begin
                        done_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            reload    <= '0;
            done_q    <= 1'b0;
            ena_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            reload    <= reload_n;
            done_q    <= done_n;
            // Decoded from the next state so the flops line up with the state they describe.
            ena_q     <= (state_n == RUN);
            busy_q    <= (state_n == RUN);
            // rdata trails remaining by one cycle.
            rdata_q   <= remaining;
        end
    end

    assign bus.timer_ena = ena_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer -- self-checking bench for tick_timer.
// Directed scenarios use a divider model with period M=4; the random scenario drives
// tick directly and compares against a behavioural model of the timer's rules.
module tb_tick_timer;

    localparam int CNT_W = 12;
    localparam int M     = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tick_timer_if #(.CNT_W(CNT_W)) bus ();

    tick_timer #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- divider model ----------------
    logic       use_div  = 1'b1;
    logic       tick_man = 1'b0;
    logic [2:0] div_cnt  = '0;
    logic       div_tick;

    always @(posedge clk) begin
        if (bus.timer_ena !== 1'b1) div_cnt <= '0;
        else if (div_cnt == 3'(M - 1)) div_cnt <= '0;
        else div_cnt <= div_cnt + 3'd1;
    end

    assign div_tick = (bus.timer_ena === 1'b1) && (div_cnt == 3'(M - 1));

    always_comb bus.tick = use_div ? div_tick : tick_man;

    // ---------------- counters / scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [CNT_W+2:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.wr    = 1'b0;
        bus.wdata = '0;
        bus.rd    = 1'b0;
        tick_man  = 1'b0;
    endtask

    task automatic do_write(input logic [CNT_W-1:0] v);
        bus.wr    = 1'b1;
        bus.wdata = v;
        step();
        bus.wr    = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic do_read();
        bus.rd = 1'b1;
        step();
        bus.rd = 1'b0;
    endtask

    task automatic wait_tick_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks the programmer-visible meaning: count left, whether the divider is enabled,
    // whether enable is pending after a restart, and the sticky flag.
    logic [CNT_W-1:0] m_rem, m_reload;
    bit m_done, m_ena, m_armed;

    task automatic model_step(input bit r, input bit w, input logic [CNT_W-1:0] wd,
                              input bit rdv, input bit tk);
        logic [CNT_W-1:0] rdata_next;
        rdata_next = m_rem;
        if (r) begin
            m_rem = 0; m_reload = 0; m_done = 0; m_ena = 0; m_armed = 0;
            rdata_next = 0;
        end else if (w) begin
            if (wd != 0) begin
                m_rem = wd; m_reload = wd; m_done = 0; m_ena = 0; m_armed = 1;
            end else begin
                m_rem = 0; m_done = 1; m_ena = 0; m_armed = 0;
            end
        end else if (m_armed) begin
            m_ena = 1; m_armed = 0;
        end else if (m_ena) begin
`ifdef TICK_TIMER_AUTORELOAD_EN
            if (rdv) m_done = 0;
`endif
            if (tk) begin
                if (m_rem > 1) m_rem = m_rem - 1;
                else begin
                    m_done = 1;
`ifdef TICK_TIMER_AUTORELOAD_EN
                    m_rem = m_reload;
`else
                    m_rem = 0;
                    m_ena = 0;
`endif
                end
            end
        end else if (rdv && m_done) begin
            m_done = 0;
        end
        exp_q.push_back({m_ena, m_ena, m_done, rdata_next});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [CNT_W+2:0] got;
        bit ena_seen;
        drive_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got = {bus.timer_ena, bus.busy, bus.done, bus.rdata};
        n_cmp++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        do_write('0);
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_write_done: got %b expected 1", bus.done);
        end
        ena_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.timer_ena !== 1'b0) ena_seen = 1'b1;
            step();
        end
        n_cmp++;
        if (ena_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write_ena: got %b expected 0", ena_seen);
        end
        do_read();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write_ack: got %b expected 0", bus.done);
        end
    endtask

    task automatic test_single_shot();
        int rise;
        do_write(12'd3);
        n_cmp++;
        if (bus.timer_ena !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_gap: ena %b busy %b expected 0 0", bus.timer_ena, bus.busy);
        end
        step();
        n_cmp++;
        if (bus.timer_ena !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_entry: ena %b busy %b expected 1 1", bus.timer_ena, bus.busy);
        end
        rise = cyc;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.done === 1'b1) break;
        end
        n_cmp++;
        if (cyc - rise != 3 * M) begin
            n_fail++;
            $display("FAIL interval_len: got %0d cycles expected %0d", cyc - rise, 3 * M);
        end
        n_cmp++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.timer_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_flags: done %b busy %b ena %b expected 1 0 0",
                     bus.done, bus.busy, bus.timer_ena);
        end
        step();
        n_cmp++;
        if (bus.rdata !== 12'd0) begin
            n_fail++;
            $display("FAIL expiry_rdata: got %0d expected 0", bus.rdata);
        end
        do_read();
        step();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_reload_on_tick();
        bit ok;
        int ticks;
        int rise;
        do_write(12'd5);
        step();
        for (int k = 0; k < 2; k++) begin
            wait_tick_high(ok);
            step();
        end
        wait_tick_high(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reload_tick_wait: got timeout expected tick");
        end
        do_write(12'd2);
        n_cmp++;
        if (bus.timer_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_gap: got ena %b expected 0", bus.timer_ena);
        end
        step();
        rise = cyc;
        n_cmp++;
        if (bus.timer_ena !== 1'b1 || bus.rdata !== 12'd2) begin
            n_fail++;
            $display("FAIL reload_value: ena %b rdata %0d expected 1 2", bus.timer_ena, bus.rdata);
        end
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done === 1'b1) break;
            if (bus.tick === 1'b1) ticks++;
            step();
        end
        n_cmp++;
        if (ticks != 2 || bus.done !== 1'b1 || cyc - rise != 2 * M) begin
            n_fail++;
            $display("FAIL reload_expiry: ticks %0d done %b cycles %0d expected 2 1 %0d",
                     ticks, bus.done, cyc - rise, 2 * M);
        end
        do_read();
    endtask

    task automatic test_rst_mid_run();
        bit bad;
        do_write(12'd2);
        step();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.rdata !== 12'd2) begin
            n_fail++;
            $display("FAIL pre_rst_run: busy %b rdata %0d expected 1 2", bus.busy, bus.rdata);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({bus.timer_ena, bus.busy, bus.done, bus.rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_run: ena %b busy %b done %b rdata %0d expected all 0",
                     bus.timer_ena, bus.busy, bus.done, bus.rdata);
        end
        use_div  = 1'b0;
        tick_man = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if ({bus.timer_ena, bus.busy, bus.done, bus.rdata} !== '0) bad = 1'b1;
        end
        tick_man = 1'b0;
        use_div  = 1'b1;
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL tick_while_disabled: got activity expected all 0");
        end
    endtask

    task automatic test_wr_rd_collision();
        do_write('0);
        bus.rd = 1'b1;
        do_write(12'd4);
        bus.rd = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_done: got %b expected 0", bus.done);
        end
        step();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.rdata !== 12'd4) begin
            n_fail++;
            $display("FAIL collide_run: busy %b rdata %0d expected 1 4", bus.busy, bus.rdata);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

`ifdef TICK_TIMER_AUTORELOAD_EN
    task automatic test_autoreload();
        bit ok;
        do_write(12'd2);
        step();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                wait_tick_high(ok);
                step();
            end
            n_cmp++;
            if (bus.done !== 1'b1 || bus.timer_ena !== 1'b1) begin
                n_fail++;
                $display("FAIL autoreload_period%0d: done %b ena %b expected 1 1",
                         p, bus.done, bus.timer_ena);
            end
            n_cmp++;
            if (bus.rdata !== 12'd1) begin
                n_fail++;
                $display("FAIL autoreload_rdata%0d: got %0d expected 1", p, bus.rdata);
            end
            do_read();
            n_cmp++;
            if (bus.done !== 1'b0 || bus.rdata !== 12'd2) begin
                n_fail++;
                $display("FAIL autoreload_ack%0d: done %b rdata %0d expected 0 2",
                         p, bus.done, bus.rdata);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [CNT_W+2:0] got;
        logic [CNT_W+2:0] exp;
        bit r, w, rdv, tk;
        logic [CNT_W-1:0] wd;
        int sel;
        use_div = 1'b0;
        exp_q.delete();
        m_rem = 0; m_reload = 0; m_done = 0; m_ena = 0; m_armed = 0;
        rst = 1'b1;
        step();
        for (int i = 0; i < 2000; i++) begin
            r   = ($urandom_range(0, 99) == 0);
            w   = ($urandom_range(0, 15) == 0);
            rdv = ($urandom_range(0, 7) == 0);
            tk  = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 7);
            if (sel == 0) wd = '0;
            else if (sel == 1) wd = '1;
            else wd = CNT_W'($urandom_range(1, 6));
            rst       = r;
            bus.wr    = w;
            bus.wdata = wd;
            bus.rd    = rdv;
            tick_man  = tk;
            model_step(r, w, wd, rdv, tk);
            step();
            exp = exp_q.pop_front();
            got = {bus.timer_ena, bus.busy, bus.done, bus.rdata};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got ena/busy/done/rdata %h expected %h", i, got, exp);
            end
        end
        rst = 1'b0;
        drive_idle();
        use_div = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_single_shot();
        test_reload_on_tick();
        test_rst_mid_run();
        test_wr_rd_collision();
`ifdef TICK_TIMER_AUTORELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
